// File: rtl/puf_uart_pkg.sv
// Shared definitions for the PUF host link: state encodings, the default frame
// marker and the baud divisor helper used by the UART receive path.
package puf_uart_pkg;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        P_HDR,
        P_HI,
        P_LO,
        P_CHK
    } parser_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_challenge_rx_if.sv
// Challenge delivery bundle from the UART frame parser to the PUF control logic.
interface uart_challenge_rx_if #(
    parameter int CHAL_W = 10
);
    logic [CHAL_W-1:0] challenge;
    logic              chal_valid;
    logic              frame_err;
    logic              busy;

    modport master (output challenge, output chal_valid, output frame_err, output busy);
    modport slave  (input  challenge, input  chal_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop line synchroniser, centre-sampling FSM and baud counter.
// Returns to idle at the stop-bit centre so back-to-back bytes are never missed.
module uart_rx_byte
    import puf_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK100MHZ,
    input  logic       counter_reset,
    input  logic       uart_txd_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  sync_q;
    logic        rx_prev;
    logic        rx_s;
    rx_state_t   state, state_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        valid_nxt, err_nxt;

    assign rx_s      = sync_q[1];
    assign byte_data = shreg;

    always_ff @(posedge CLK100MHZ or posedge counter_reset) begin
        if (counter_reset) begin
            sync_q  <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], uart_txd_in};
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge counter_reset) begin
        if (counter_reset) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            byte_valid <= valid_nxt;
            stop_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt + 16'd1;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        valid_nxt    = 1'b0;
        err_nxt      = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_cnt_nxt = '0;
                if (rx_prev && !rx_s) begin
                    state_nxt   = RX_START;
                    bit_idx_nxt = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (baud_cnt == HALF_END) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (baud_cnt == BIT_END) begin
                    baud_cnt_nxt = '0;
                    shreg_nxt    = {rx_s, shreg[7:1]};
                    bit_idx_nxt  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt == BIT_END) begin
                    baud_cnt_nxt = '0;
                    valid_nxt    = rx_s;
                    err_nxt      = !rx_s;
                    state_nxt    = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_challenge_rx.sv
// Host-to-FPGA challenge receiver: parses [A5, hi, lo] frames into a CHAL_W challenge.
// Optional `UART_CHAL_CHECKSUM_EN adds a trailing hi^lo check byte to each frame.
module uart_challenge_rx
    import puf_uart_pkg::*;
#(
    parameter int         CLK_FREQ     = 100000000,
    parameter int         BAUD         = 115200,
    parameter int         CHAL_W       = 10,
    parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEFAULT,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic                 CLK100MHZ,
    input  logic                 counter_reset,
    input  logic                 uart_txd_in,
    uart_challenge_rx_if.master  chal_if
);
    localparam int          CPB     = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [31:0] TO_END  = 32'(TIMEOUT_BITS * CPB - 1);
    // Bits of the hi byte that fall outside the challenge must be zero.
    localparam logic [7:0]  HI_MASK = 8'hFF << (CHAL_W - 8);

    logic          byte_valid, stop_err;
    logic [7:0]    byte_data;
    parser_state_t pstate, pstate_nxt;
    logic [7:0]    hi_q;
    logic [31:0]   gap_cnt;
    logic          hi_ld, commit, reject;
`ifdef UART_CHAL_CHECKSUM_EN
    logic [7:0]    lo_q;
    logic          lo_ld;
`endif

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx_byte (
        .CLK100MHZ    (CLK100MHZ),
        .counter_reset(counter_reset),
        .uart_txd_in  (uart_txd_in),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .stop_err     (stop_err)
    );

    assign chal_if.busy = (pstate != P_HDR);

    always_comb begin
        pstate_nxt = pstate;
        hi_ld      = 1'b0;
        commit     = 1'b0;
        reject     = 1'b0;
`ifdef UART_CHAL_CHECKSUM_EN
        lo_ld      = 1'b0;
`endif
        if (stop_err) begin
            reject     = 1'b1;
            pstate_nxt = P_HDR;
        end else if (byte_valid) begin
            case (pstate)
                P_HDR: if (byte_data == HDR_BYTE) pstate_nxt = P_HI;
                P_HI: begin
                    if ((byte_data & HI_MASK) != 8'd0) begin
                        reject     = 1'b1;
                        pstate_nxt = P_HDR;
                    end else begin
                        hi_ld      = 1'b1;
                        pstate_nxt = P_LO;
                    end
                end
`ifdef UART_CHAL_CHECKSUM_EN
                P_LO: begin
                    lo_ld      = 1'b1;
                    pstate_nxt = P_CHK;
                end
                P_CHK: begin
                    commit     = (byte_data == (hi_q ^ lo_q));
                    reject     = !commit;
                    pstate_nxt = P_HDR;
                end
`else
                P_LO: begin
                    commit     = 1'b1;
                    pstate_nxt = P_HDR;
                end
`endif
                default: pstate_nxt = P_HDR;
            endcase
        end else if (pstate != P_HDR && gap_cnt == TO_END) begin
            reject     = 1'b1;
            pstate_nxt = P_HDR;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge counter_reset) begin
        if (counter_reset) begin
            pstate             <= P_HDR;
            hi_q               <= '0;
            gap_cnt            <= '0;
            chal_if.challenge  <= '0;
            chal_if.chal_valid <= 1'b0;
            chal_if.frame_err  <= 1'b0;
`ifdef UART_CHAL_CHECKSUM_EN
            lo_q               <= '0;
`endif
        end else begin
            pstate             <= pstate_nxt;
            chal_if.chal_valid <= commit;
            chal_if.frame_err  <= reject;
            if (hi_ld) hi_q <= byte_data;
            // Inter-byte gap only matters once a header has been seen.
            if (pstate == P_HDR || byte_valid) gap_cnt <= '0;
            else                               gap_cnt <= gap_cnt + 32'd1;
`ifdef UART_CHAL_CHECKSUM_EN
            if (lo_ld)  lo_q <= byte_data;
            if (commit) chal_if.challenge <= CHAL_W'({hi_q, lo_q});
`else
            if (commit) chal_if.challenge <= CHAL_W'({hi_q, byte_data});
`endif
        end
    end
endmodule

// File: tb/tb_uart_challenge_rx.sv
// Directed bench for uart_challenge_rx at 16 clocks per bit (1.8432 MHz / 115200 baud).
// Honours `UART_CHAL_CHECKSUM_EN by appending the hi^lo byte to every good frame.
module tb_uart_challenge_rx;
    localparam int CPB = 16;

    logic CLK100MHZ     = 1'b0;
    logic counter_reset = 1'b1;
    logic uart_txd_in   = 1'b1;

    int checks = 0;
    int errors = 0;
    int cv_pulses = 0, cv_cycles = 0, fe_pulses = 0, overlap = 0;
    int cv_base, fe_base;
    logic cv_prev = 1'b0, fe_prev = 1'b0;

    uart_challenge_rx_if #(.CHAL_W(10)) chal_if ();

    uart_challenge_rx #(
        .CLK_FREQ(1843200),
        .BAUD    (115200)
    ) dut (
        .CLK100MHZ    (CLK100MHZ),
        .counter_reset(counter_reset),
        .uart_txd_in  (uart_txd_in),
        .chal_if      (chal_if)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(negedge CLK100MHZ) begin
        if (chal_if.chal_valid) cv_cycles++;
        if (chal_if.chal_valid && !cv_prev) cv_pulses++;
        if (chal_if.frame_err && !fe_prev) fe_pulses++;
        if (chal_if.chal_valid && chal_if.frame_err) overlap++;
        cv_prev = chal_if.chal_valid;
        fe_prev = chal_if.frame_err;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line_for(input logic v, input int clks);
        uart_txd_in = v;
        repeat (clks) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic idle_bits(input int n);
        line_for(1'b1, n * CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        line_for(1'b0, CPB);
        for (int i = 0; i < 8; i++) line_for(b[i], CPB);
        line_for(stop_v, CPB);
        uart_txd_in = 1'b1;
    endtask

    task automatic mark();
        cv_base = cv_pulses;
        fe_base = fe_pulses;
    endtask

    task automatic settle();
        idle_bits(2);
        @(negedge CLK100MHZ);
    endtask

    initial begin
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        check("rst_challenge", int'(chal_if.challenge), 0);
        check("rst_chal_valid", int'(chal_if.chal_valid), 0);
        check("rst_frame_err", int'(chal_if.frame_err), 0);
        check("rst_busy", int'(chal_if.busy), 0);
        #1 counter_reset = 1'b0;
        idle_bits(2);

        // Good frame, max challenge value
        mark();
        send_byte(8'hA5, 1'b1);
        @(negedge CLK100MHZ);
        check("busy_after_hdr", int'(chal_if.busy), 1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hFF, 1'b1);
`ifdef UART_CHAL_CHECKSUM_EN
        send_byte(8'hFC, 1'b1);
`endif
        settle();
        check("f1_challenge", int'(chal_if.challenge), 'h3FF);
        check("f1_cv_pulses", cv_pulses - cv_base, 1);
        check("f1_cv_width", cv_cycles, cv_pulses);
        check("f1_no_err", fe_pulses - fe_base, 0);
        check("f1_busy", int'(chal_if.busy), 0);

        // Leading junk before the header is ignored
        mark();
        send_byte(8'h5A, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
`ifdef UART_CHAL_CHECKSUM_EN
        send_byte(8'h22, 1'b1);
`endif
        settle();
        check("f2_challenge", int'(chal_if.challenge), 'h123);
        check("f2_cv_pulses", cv_pulses - cv_base, 1);
        check("f2_no_err", fe_pulses - fe_base, 0);

        // Hi byte out of range
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        settle();
        check("hi_err_pulse", fe_pulses - fe_base, 1);
        check("hi_err_busy", int'(chal_if.busy), 0);
        send_byte(8'h10, 1'b1);
        settle();
        check("hi_err_hold", int'(chal_if.challenge), 'h123);
        check("hi_err_no_cv", cv_pulses - cv_base, 0);
        check("hi_err_10_ignored", int'(chal_if.busy), 0);

        // Inter-byte timeout
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle_bits(28);
        @(negedge CLK100MHZ);
        check("to_busy_before", int'(chal_if.busy), 1);
        check("to_no_err_before", fe_pulses - fe_base, 0);
        idle_bits(6);
        @(negedge CLK100MHZ);
        check("to_busy_after", int'(chal_if.busy), 0);
        check("to_err_pulse", fe_pulses - fe_base, 1);
        idle_bits(6);
        send_byte(8'h55, 1'b1);
        settle();
        check("to_hold", int'(chal_if.challenge), 'h123);
        check("to_55_ignored", int'(chal_if.busy), 0);
        check("to_no_cv", cv_pulses - cv_base, 0);

        // Framing error inside a frame
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b0);
        settle();
        check("stop_err_pulse", fe_pulses - fe_base, 1);
        check("stop_err_busy", int'(chal_if.busy), 0);

        // Short glitch mid-frame must not become a byte
        mark();
        send_byte(8'hA5, 1'b1);
        idle_bits(1);
        line_for(1'b0, 5);
        idle_bits(2);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
`ifdef UART_CHAL_CHECKSUM_EN
        send_byte(8'h36, 1'b1);
`endif
        settle();
        check("glitch_no_err", fe_pulses - fe_base, 0);
        check("glitch_challenge", int'(chal_if.challenge), 'h234);

        // Reset in the middle of the lo byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        line_for(1'b0, CPB);
        line_for(1'b0, 4 * CPB + 3);
        #2 counter_reset = 1'b1;
        uart_txd_in = 1'b1;
        @(negedge CLK100MHZ);
        check("mid_rst_challenge", int'(chal_if.challenge), 0);
        check("mid_rst_busy", int'(chal_if.busy), 0);
        #1 counter_reset = 1'b0;
        idle_bits(2);
        mark();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h34, 1'b1);
`ifdef UART_CHAL_CHECKSUM_EN
        send_byte(8'h36, 1'b1);
`endif
        settle();
        check("post_rst_challenge", int'(chal_if.challenge), 'h234);
        check("post_rst_cv", cv_pulses - cv_base, 1);
        check("never_both", overlap, 0);
        check("cv_single_cycle", cv_cycles, cv_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
